pc_seq: RTL

//   Program-counter sequencer and core run-state controller for the pico core.

---
 rtl/pc_seq.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/pc_seq.sv
// Program-counter sequencer and run-state controller: owns PC, return stack and fetch enable.
// Latency: pc_o updates on the edge that samples the decoder; HALT/WFI exit takes one cycle to run_o=1.
// Backpressure: none accepted; run_o drops in BOOT/HALT/WFI and decoder inputs are ignored while it is low.

package pc_seq_pkg;
    typedef enum logic [1:0] {
        MODE_INC = 2'd0,
        MODE_REL = 2'd1,
        MODE_SUB = 2'd2,
        MODE_RET = 2'd3
    } mode_pc_e;
endpackage

module pc_seq #(
    parameter int              PC_W      = 8,
    parameter int              STACK_D   = 4,
    parameter logic [PC_W-1:0] RESET_VEC = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  pc_seq_pkg::mode_pc_e  mode_pc_i,
    input  logic [PC_W-1:0]       rel_off_i,
    input  logic [PC_W-1:0]       tgt_i,
    input  logic                  halt_core_i,
    input  logic                  wfi_core_i,
    input  logic                  ext_int_i,
    input  logic                  resume_i,
    input  logic                  clr_err_i,
    output logic [PC_W-1:0]       pc_o,
    output logic                  run_o,
    output logic                  halted_o,
    output logic                  waiting_o,
    output logic                  stack_empty_o,
    output logic                  stack_ovf_o,
    output logic                  stack_unf_o
);
    import pc_seq_pkg::*;

    // sp counts 0..STACK_D; the write index wraps over STACK_D slots
    localparam int SP_W = $clog2(STACK_D + 1);
    localparam int IX_W = (STACK_D > 1) ? $clog2(STACK_D) : 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_D);
    localparam logic [IX_W-1:0] IX_LAST = IX_W'(STACK_D - 1);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2,
        ST_WFI  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d, pc_inc;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic [IX_W-1:0]   wp_q, wp_d, wp_inc, wp_dec;
    logic [PC_W-1:0]   stk_q [STACK_D];
    logic              push, pop_empty;
    logic              ovf_q, ovf_d, unf_q, unf_d;

    assign pc_inc = pc_q + PC_W'(1);
    // Write index steps circularly, so a push on a full stack overwrites the oldest entry
    assign wp_inc = (wp_q == IX_LAST) ? '0 : wp_q + IX_W'(1);
    assign wp_dec = (wp_q == '0) ? IX_LAST : wp_q - IX_W'(1);

    // Next-state, PC and stack-pointer decode; decoder inputs only matter in RUN
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        sp_d      = sp_q;
        wp_d      = wp_q;
        push      = 1'b0;
        pop_empty = 1'b0;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (halt_core_i) begin
                    state_d = ST_HALT;
                end else if (wfi_core_i) begin
                    state_d = ST_WFI;
                end else begin
                    case (mode_pc_i)
                        MODE_INC: pc_d = pc_inc;
                        MODE_REL: pc_d = pc_q + rel_off_i;
                        MODE_SUB: begin
                            push = 1'b1;
                            pc_d = tgt_i;
                            wp_d = wp_inc;
                            if (sp_q != SP_FULL) begin
                                sp_d = sp_q + SP_W'(1);
                            end
                        end
                        MODE_RET: begin
                            if (sp_q != '0) begin
                                pc_d = stk_q[wp_dec];
                                wp_d = wp_dec;
                                sp_d = sp_q - SP_W'(1);
                            end else begin
                                pop_empty = 1'b1;
                                pc_d      = RESET_VEC;
                            end
                        end
                        default: pc_d = pc_inc;
                    endcase
                end
            end
            ST_HALT: begin
                if (resume_i) begin
                    state_d = ST_RUN;
                    pc_d    = pc_inc;
                end
            end
            ST_WFI: begin
                if (ext_int_i) begin
                    state_d = ST_RUN;
                    pc_d    = pc_inc;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    // Sticky error flags: a new error in the same cycle as a clear keeps the flag set
    always_comb begin
        ovf_d = (ovf_q & ~clr_err_i) | (push & (sp_q == SP_FULL));
        unf_d = (unf_q & ~clr_err_i) | pop_empty;
    end

    // Control state, PC, stack pointers and error flags
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_VEC;
            sp_q    <= '0;
            wp_q    <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            wp_q    <= wp_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Return-stack storage; cleared on reset so no stale return address survives
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < STACK_D; i++) begin
                stk_q[i] <= '0;
            end
        end else if (push) begin
            stk_q[wp_q] <= pc_inc;
        end
    end

    assign pc_o          = pc_q;
    assign run_o         = (state_q == ST_RUN);
    assign halted_o      = (state_q == ST_HALT);
    assign waiting_o     = (state_q == ST_WFI);
    assign stack_empty_o = (sp_q == '0);
    assign stack_ovf_o   = ovf_q;
    assign stack_unf_o   = unf_q;

endmodule
